// File: rtl/music_player_pkg.sv
// Shared constants, FSM encoding and half-period helper for the music player.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Note numbering: index 24 = A4 (440 Hz), +1 per semitone, 0 = rest.
// The tone table covers notes NOTE_MIN..NOTE_MAX (A3..G#5); anything else is a rest.
package music_player_pkg;

    localparam int NOTE_W        = 8;
    localparam int NOTE_REST     = 0;
    localparam int NOTE_A4       = 24;
    localparam int NOTE_MIN      = 12;
    localparam int NOTE_MAX      = 47;
    localparam int HALF_PERIOD_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // round(clk_hz / (2 * f(note))), 0 for notes outside the table.
    // Frequencies are held in millihertz for the A3..G#3 octave shape (A4 octave values);
    // the octave offset is folded into the divisor so only one octave of constants is needed.
    function automatic logic [HALF_PERIOD_W-1:0] calc_half_period(input longint clk_hz,
                                                                  input int     note);
        longint base_mhz;
        longint denom;
        longint num;
        int     offs;
        int     semi;
        int     octave;
        base_mhz = 64'd440000;
        if (note < NOTE_MIN || note > NOTE_MAX) begin
            return '0;
        end
        offs   = note - NOTE_MIN;   // 0..35
        semi   = offs % 12;
        octave = offs / 12;         // 0 = A3 octave, 1 = A4, 2 = A5
        case (semi)
            0:       base_mhz = 64'd440000;
            1:       base_mhz = 64'd466164;
            2:       base_mhz = 64'd493883;
            3:       base_mhz = 64'd523251;
            4:       base_mhz = 64'd554365;
            5:       base_mhz = 64'd587330;
            6:       base_mhz = 64'd622254;
            7:       base_mhz = 64'd659255;
            8:       base_mhz = 64'd698456;
            9:       base_mhz = 64'd739989;
            10:      base_mhz = 64'd783991;
            default: base_mhz = 64'd830609;
        endcase
        // A3 octave: f = base/2, so 2*f = base; each octave up doubles the divisor.
        denom = base_mhz << octave;
        num   = clk_hz * 64'd1000;
        return HALF_PERIOD_W'((num + denom / 2) / denom);
    endfunction

endpackage

// File: rtl/note_period_lut.sv
// Note index to square-wave half-period lookup (0 = rest / out of table).
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   note         in  8   note index (24 = A4)
//   half_period  out 17  clocks per half cycle of the tone at CLK_HZ, 0 for rest
module note_period_lut
    import music_player_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic [NOTE_W-1:0]        note,
    output logic [HALF_PERIOD_W-1:0] half_period
);

    // Every entry is a constant, so this folds to a plain ROM.
    logic [HALF_PERIOD_W-1:0] hp_tab [NOTE_MIN:NOTE_MAX];

    for (genvar g = NOTE_MIN; g <= NOTE_MAX; g++) begin : g_tab
        assign hp_tab[g] = calc_half_period(longint'(CLK_HZ), g);
    end

    always_comb begin
        half_period = '0;
        for (int i = NOTE_MIN; i <= NOTE_MAX; i++) begin
            if (note == NOTE_W'(i)) begin
                half_period = hp_tab[i];
            end
        end
    end

endmodule

// File: rtl/music_player.sv
// Song sequencer: steps the note ROM at a fixed tempo and plays each note as a square wave.
// Latency: cur_note follows rom_address by 2 cycles (registered ROM + capture); audio is registered.
// Backpressure: none; the ROM always answers one cycle after the address.
//
// Build option: MUSIC_PLAYER_LOOP_EN - when defined the song wraps to address 0 and keeps
// playing; otherwise the player parks in DONE until play is dropped and raised again.
//
// Ports:
//   clk          in   1  system clock
//   reset        in   1  synchronous, active-high
//   play         in   1  level: 1 = run song, 0 = stop and rewind
//   rom_address  out  8  registered song ROM address
//   rom_note     in   8  ROM data, valid one cycle after rom_address
//   audio        out  1  square-wave tone, 0 during rest/idle
//   cur_note     out  8  note index currently sounding
//   playing      out  1  high while in PLAY
//   song_done    out  1  one-cycle pulse in the cycle the last entry's step ends
module music_player
    import music_player_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int TICKS_PER_STEP = 6_250_000,
    parameter int SONG_LEN       = 241
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    output logic [NOTE_W-1:0] rom_address,
    input  logic [NOTE_W-1:0] rom_note,
    output logic              audio,
    output logic [NOTE_W-1:0] cur_note,
    output logic              playing,
    output logic              song_done
);

    localparam int              STEP_W    = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(TICKS_PER_STEP - 1);
    localparam logic [NOTE_W-1:0] ADDR_LAST = NOTE_W'(SONG_LEN - 1);

`ifdef MUSIC_PLAYER_LOOP_EN
    localparam state_t END_STATE = ST_PLAY;
`else
    localparam state_t END_STATE = ST_DONE;
`endif

    state_t                   state;
    state_t                   state_next;
    logic [STEP_W-1:0]        step_cnt;
    logic                     fetch_live;
    logic [HALF_PERIOD_W-1:0] tone_cnt;
    logic [HALF_PERIOD_W-1:0] half_period;
    logic                     step_end;
    logic                     song_end;

    note_period_lut #(
        .CLK_HZ (CLK_HZ)
    ) u_lut (
        .note        (cur_note),
        .half_period (half_period)
    );

    assign step_end  = (state == ST_PLAY) && (step_cnt == STEP_LAST);
    assign song_end  = step_end && (rom_address == ADDR_LAST);
    // Dropping play in the final cycle aborts the song, so no completion pulse then.
    assign song_done = song_end && play;
    assign playing   = (state == ST_PLAY);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (play) begin
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (!play) begin
                    state_next = ST_IDLE;
                end else if (song_end) begin
                    state_next = END_STATE;
                end
            end
            ST_DONE: begin
                if (!play) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- step counter, fetch capture, tone generator ----------------
    always_ff @(posedge clk) begin
        if (reset || (state_next != ST_PLAY)) begin
            // Leaving PLAY (or never in it): everything back to the rewound, silent state.
            step_cnt    <= '0;
            rom_address <= '0;
            fetch_live  <= 1'b0;
            cur_note    <= '0;
            tone_cnt    <= '0;
            audio       <= 1'b0;
        end else begin
            // rom_note only reflects a PLAY-issued address from the second PLAY cycle on.
            fetch_live <= (state == ST_PLAY);

            if (state != ST_PLAY) begin
                step_cnt    <= '0;
                rom_address <= '0;
            end else if (step_end) begin
                step_cnt    <= '0;
                rom_address <= song_end ? '0 : rom_address + 1'b1;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end

            // A repeated note is not a change, so the tone runs on without a phase restart.
            if (fetch_live && (rom_note != cur_note)) begin
                cur_note <= rom_note;
                tone_cnt <= '0;
                audio    <= 1'b0;
            end else if (half_period == '0) begin
                tone_cnt <= '0;
                audio    <= 1'b0;
            end else if (tone_cnt == half_period - 1'b1) begin
                tone_cnt <= '0;
                audio    <= ~audio;
            end else begin
                tone_cnt <= tone_cnt + 1'b1;
            end
        end
    end

endmodule
